i2c_slave_port: RTL and testbench

I2C target (slave) that sits directly downstream of the peripheral-bus I2C master on the SDA/SCL pair and terminates its transactions. The block decodes one 7-bit address. It captures 1–4 written bytes into a word, and serves 1–4 bytes for reads. It uses the same MSB-first bit order and most-significant-byte-first byte order as the master, so a master NBY/TDR/RDR transfer round-trips through this block unchanged. The block runs entirely on the system clock and oversamples the bus.

---
 rtl/i2c_slave_port.sv | 250 +++++++++++++++++++++++++
 tb/tb_i2c_slave_port.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_port.sv
// rtl/i2c_slave_port.sv - I2C target with 7-bit address decode, 1-4 byte write capture and 1-4 byte read serving
//
// Ports:
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   scl_i                 bus clock from the master (oversampled)
//   sda_io                open-drain data, driven only to 0 or released
//   tx_data_i, tx_nby_i   read payload (byte k at [8k+7:8k]) and byte count, clamped to 1..4
//   rx_data_o, rx_nby_o   last committed write payload (right-aligned) and its byte count
//   rx_valid_o            one-cycle pulse when a write of at least one byte commits
//   tx_done_o             one-cycle pulse when an addressed read ends
//   busy_o                high from address match to the end of the transaction
module i2c_slave_port #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        scl_i,
    inout  wire         sda_io,
    input  logic [31:0] tx_data_i,
    input  logic [2:0]  tx_nby_i,
    output logic [31:0] rx_data_o,
    output logic [2:0]  rx_nby_o,
    output logic        rx_valid_o,
    output logic        tx_done_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
    } state_t;

    logic        scl_s1_q, scl_s2_q, scl_prev_q;
    logic        sda_s1_q, sda_s2_q, sda_prev_q;
    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [7:0]  sh_q;
    logic        phase_q;
    logic        is_read_q;
    logic        rd_active_q;
    logic        accept_q;
    logic [2:0]  n_q;
    logic [31:0] shadow_q;
    logic [2:0]  wcnt_q;
    logic        sda_oe_q;

    logic        scl_rise, scl_fall, sda_rise, sda_fall;
    logic        start_det, stop_det;
    logic [7:0]  byte_d;
    logic [2:0]  nby_d;
    logic [7:0]  first_byte_d;
    logic [7:0]  next_byte_d;

    // Byte n-1 of the payload, where n is a 1..4 remaining-byte count.
    function automatic logic [7:0] sel_byte(input logic [31:0] d, input logic [2:0] n);
        case (n)
            3'd1:    sel_byte = d[7:0];
            3'd2:    sel_byte = d[15:8];
            3'd3:    sel_byte = d[23:16];
            default: sel_byte = d[31:24];
        endcase
    endfunction

    assign sda_io = sda_oe_q ? 1'b0 : 1'bz;

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign sda_rise  = sda_s2_q & ~sda_prev_q;
    assign sda_fall  = ~sda_s2_q & sda_prev_q;
    // SCL must be stably high across both samples so a data change near an SCL edge never aliases as START/STOP.
    assign start_det = sda_fall & scl_s2_q & scl_prev_q;
    assign stop_det  = sda_rise & scl_s2_q & scl_prev_q;
    assign byte_d    = {sh_q[6:0], sda_s2_q};

    always_comb begin
        nby_d = tx_nby_i;
        if (tx_nby_i == 3'd0) begin
            nby_d = 3'd1;
        end else if (tx_nby_i > 3'd4) begin
            nby_d = 3'd4;
        end
        first_byte_d = sel_byte(tx_data_i, nby_d);
        // Once the last payload byte has been acknowledged, every further byte reads as all-ones (bus released).
        next_byte_d  = (n_q > 3'd1) ? sel_byte(tx_data_i, n_q - 3'd1) : 8'hFF;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda_io;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd7;
            sh_q        <= 8'd0;
            phase_q     <= 1'b0;
            is_read_q   <= 1'b0;
            rd_active_q <= 1'b0;
            accept_q    <= 1'b0;
            n_q         <= 3'd0;
            shadow_q    <= 32'd0;
            wcnt_q      <= 3'd0;
            sda_oe_q    <= 1'b0;
            rx_data_o   <= 32'd0;
            rx_nby_o    <= 3'd0;
            rx_valid_o  <= 1'b0;
            tx_done_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            tx_done_o  <= 1'b0;
            if (start_det || stop_det) begin
                // A repeated START ends the previous transaction exactly like STOP before re-entering ADDR.
                if (wcnt_q != 3'd0) begin
                    rx_data_o  <= shadow_q;
                    rx_nby_o   <= wcnt_q;
                    rx_valid_o <= 1'b1;
                end
                if (rd_active_q) begin
                    tx_done_o <= 1'b1;
                end
                rd_active_q <= 1'b0;
                busy_o      <= 1'b0;
                sda_oe_q    <= 1'b0;
                phase_q     <= 1'b0;
                shadow_q    <= 32'd0;
                wcnt_q      <= 3'd0;
                cnt_q       <= 3'd7;
                sh_q        <= 8'd0;
                state_q     <= start_det ? S_ADDR : S_IDLE;
            end else begin
                case (state_q)
                    S_ADDR: begin
                        if (scl_rise) begin
                            sh_q  <= byte_d;
                            cnt_q <= cnt_q - 3'd1;
                            if (cnt_q == 3'd0) begin
                                if (byte_d[7:1] == ADDR) begin
                                    state_q     <= S_ADDR_ACK;
                                    busy_o      <= 1'b1;
                                    is_read_q   <= byte_d[0];
                                    rd_active_q <= byte_d[0];
                                end else begin
                                    state_q <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                cnt_q   <= 3'd7;
                                if (is_read_q) begin
                                    // The fall that ends the ACK also presents the first data bit.
                                    n_q      <= nby_d;
                                    sda_oe_q <= ~first_byte_d[7];
                                    sh_q     <= {first_byte_d[6:0], 1'b1};
                                    state_q  <= S_RD_BYTE;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= S_WR_BYTE;
                                end
                            end
                        end
                    end
                    S_WR_BYTE: begin
                        if (scl_rise) begin
                            sh_q  <= byte_d;
                            cnt_q <= cnt_q - 3'd1;
                            if (cnt_q == 3'd0) begin
                                state_q <= S_WR_ACK;
                                if (wcnt_q < 3'd4) begin
                                    shadow_q <= {shadow_q[23:0], byte_d};
                                    wcnt_q   <= wcnt_q + 3'd1;
                                    accept_q <= 1'b1;
                                end else begin
                                    accept_q <= 1'b0;
                                end
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q <= accept_q;
                                phase_q  <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                phase_q  <= 1'b0;
                                cnt_q    <= 3'd7;
                                state_q  <= S_WR_BYTE;
                            end
                        end
                    end
                    S_RD_BYTE: begin
                        if (scl_fall) begin
                            if (cnt_q != 3'd0) begin
                                sda_oe_q <= ~sh_q[7];
                                sh_q     <= {sh_q[6:0], 1'b1};
                                cnt_q    <= cnt_q - 3'd1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                phase_q  <= 1'b0;
                                state_q  <= S_RD_ACK;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise && !phase_q) begin
                            if (sda_s2_q) begin
                                state_q <= S_IGNORE;
                                busy_o  <= 1'b0;
                            end else begin
                                sh_q    <= next_byte_d;
                                n_q     <= (n_q > 3'd1) ? n_q - 3'd1 : 3'd0;
                                phase_q <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            sda_oe_q <= ~sh_q[7];
                            sh_q     <= {sh_q[6:0], 1'b1};
                            cnt_q    <= 3'd7;
                            phase_q  <= 1'b0;
                            state_q  <= S_RD_BYTE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_port.sv
// tb/tb_i2c_slave_port.sv - self-checking bench for i2c_slave_port driven by a bit-level I2C master model
module tb_i2c_slave_port;

    localparam int         Q     = 5;
    localparam logic [6:0] TADDR = 7'h42;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        scl     = 1'b1;
    logic        m_low   = 1'b0;
    logic [31:0] tx_data = 32'd0;
    logic [2:0]  tx_nby  = 3'd1;
    logic [31:0] rx_data;
    logic [2:0]  rx_nby;
    logic        rx_valid, tx_done, busy;
    wire         sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_port #(.ADDR(TADDR)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl),
        .sda_io     (sda),
        .tx_data_i  (tx_data),
        .tx_nby_i   (tx_nby),
        .rx_data_o  (rx_data),
        .rx_nby_o   (rx_nby),
        .rx_valid_o (rx_valid),
        .tx_done_o  (tx_done),
        .busy_o     (busy)
    );

    int cyc, n_valid, n_done, n_drive, n_busy, n_busy_bad, valid_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (tx_done === 1'b1) n_done <= n_done + 1;
        if (m_low == 1'b0 && sda === 1'b0) n_drive <= n_drive + 1;
        if (busy === 1'b1) n_busy <= n_busy + 1;
        if ((rx_valid === 1'b1 || tx_done === 1'b1) && busy === 1'b1) n_busy_bad <= n_busy_bad + 1;
    end

    int          checks, errors;
    int          t_stop;
    logic [31:0] ref_rx;
    logic [2:0]  ref_nby;
    logic [7:0]  wbuf [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        m_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(2 * Q);
        m_low = 1'b1;
        tick(2 * Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic m_stop();
        m_low = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(2 * Q);
        t_stop = cyc;
        m_low  = 1'b0;
        tick(2 * Q);
    endtask

    task automatic m_bit(input logic bv, output logic r);
        m_low = ~bv;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        r = sda;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic m_write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(b[i], r);
        m_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic m_read_byte(input logic mack, output logic [7:0] b);
        logic r;
        b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            m_bit(1'b1, r);
            b = {b[6:0], r};
        end
        m_bit(~mack, r);
    endtask

    // Write transaction: the model keeps the first four bytes in arrival order and expects
    // an ACK only for those when the address matches.
    task automatic do_write(input logic [6:0] addr, input int nb, input string tag);
        int          v0, d0, b0, keep;
        logic        ack, match;
        logic [31:0] exp_word;
        v0 = n_valid; d0 = n_drive; b0 = n_busy;
        match = (addr == TADDR);
        m_start();
        m_write_byte({addr, 1'b0}, ack);
        check({tag, "_addr_ack"}, 32'(ack), 32'(match));
        exp_word = 32'd0;
        keep = 0;
        for (int i = 0; i < nb; i++) begin
            m_write_byte(wbuf[i], ack);
            check($sformatf("%s_ack%0d", tag, i), 32'(ack), 32'(match && i < 4));
            if (match && i < 4) begin
                exp_word = exp_word * 256 + 32'(wbuf[i]);
                keep++;
            end
        end
        m_stop();
        if (keep > 0) begin
            ref_rx  = exp_word;
            ref_nby = 3'(keep);
            check({tag, "_valid_cnt"}, 32'(n_valid - v0), 32'd1);
            check({tag, "_valid_lat"}, 32'(valid_cyc - t_stop), 32'd3);
        end else begin
            check({tag, "_valid_cnt"}, 32'(n_valid - v0), 32'd0);
        end
        if (!match) begin
            check({tag, "_no_drive"}, 32'(n_drive - d0), 32'd0);
            check({tag, "_no_busy"}, 32'(n_busy - b0), 32'd0);
        end else begin
            check({tag, "_busy_seen"}, 32'(n_busy > b0), 32'd1);
        end
        check({tag, "_rx_data"}, rx_data, ref_rx);
        check({tag, "_rx_nby"}, 32'(rx_nby), 32'(ref_nby));
    endtask

    // Read transaction: remaining count n = clamp(tx_nby, 1..4); byte i is payload byte n-1-i,
    // then all-ones once the payload is exhausted.
    task automatic do_read(input logic [31:0] txd, input int txn, input int len, input string tag);
        int          v0, dn0, n;
        logic        ack;
        logic [7:0]  b, e;
        logic [31:0] rdr, exp_rdr;
        v0 = n_valid; dn0 = n_done;
        n = (txn == 0) ? 1 : ((txn > 4) ? 4 : txn);
        tx_data = txd;
        tx_nby  = 3'(txn);
        m_start();
        m_write_byte({TADDR, 1'b1}, ack);
        check({tag, "_addr_ack"}, 32'(ack), 32'd1);
        rdr = 32'd0;
        exp_rdr = 32'd0;
        for (int i = 0; i < len; i++) begin
            m_read_byte(i < len - 1, b);
            e = (i < n) ? 8'(txd >> (8 * (n - 1 - i))) : 8'hFF;
            check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(e));
            rdr = rdr * 256 + 32'(b);
            exp_rdr = exp_rdr * 256 + 32'(e);
        end
        m_stop();
        check({tag, "_rdr"}, rdr, exp_rdr);
        check({tag, "_done_cnt"}, 32'(n_done - dn0), 32'd1);
        check({tag, "_no_valid"}, 32'(n_valid - v0), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic        ack, r;
        logic [7:0]  b, b2;
        int          v0, dn0, nb, len, txn;
        logic [6:0]  a;

        ref_rx  = 32'd0;
        ref_nby = 3'd0;
        tick(3);
        check("reset_rx_data", rx_data, 32'd0);
        check("reset_rx_nby", 32'(rx_nby), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(5);
        check("idle_sda", 32'(sda), 32'd1);
        check("idle_valid", 32'(rx_valid), 32'd0);

        wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
        do_write(TADDR, 4, "w4");
        check("w4_word", rx_data, 32'hDEADBEEF);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        do_write(TADDR, 2, "w2");
        check("w2_word", rx_data, 32'h0000A55A);

        do_read(32'h00123456, 3, 3, "r3");

        wbuf[0] = 8'h01; wbuf[1] = 8'h02;
        do_write(7'h43, 2, "mis");

        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44; wbuf[4] = 8'h55;
        do_write(TADDR, 5, "w5");
        check("w5_word", rx_data, 32'h11223344);

        // Reset while the target is holding SDA low for the ACK of byte 2.
        m_start();
        m_write_byte({TADDR, 1'b0}, ack);
        m_write_byte(8'h66, ack);
        b2 = 8'h77;
        for (int i = 7; i >= 0; i--) m_bit(b2[i], r);
        m_low = 1'b0;
        tick(Q);
        check("rst_pre_ack_low", 32'(sda), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_sda_released", 32'(sda), 32'd1);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_rx_nby", 32'(rx_nby), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        scl = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(10);
        ref_rx  = 32'd0;
        ref_nby = 3'd0;
        wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
        do_write(TADDR, 4, "w4_after_rst");

        // Repeated START commits the pending write, then an addressed read follows.
        v0 = n_valid; dn0 = n_done;
        m_start();
        m_write_byte({TADDR, 1'b0}, ack);
        m_write_byte(8'hAB, ack);
        m_write_byte(8'hCD, ack);
        tx_data = 32'h0000_0077;
        tx_nby  = 3'd1;
        m_start();
        check("rs_commit_cnt", 32'(n_valid - v0), 32'd1);
        check("rs_rx_data", rx_data, 32'h0000ABCD);
        check("rs_rx_nby", 32'(rx_nby), 32'd2);
        m_write_byte({TADDR, 1'b1}, ack);
        check("rs_addr_ack", 32'(ack), 32'd1);
        m_read_byte(1'b0, b);
        check("rs_read_byte", 32'(b), 32'h77);
        m_stop();
        check("rs_done_cnt", 32'(n_done - dn0), 32'd1);
        check("rs_no_recommit", 32'(n_valid - v0), 32'd1);
        ref_rx  = 32'h0000ABCD;
        ref_nby = 3'd2;

        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                nb = int'($urandom_range(0, 6));
                for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
                a = ($urandom_range(0, 3) == 0) ? (TADDR ^ 7'($urandom_range(1, 127))) : TADDR;
                do_write(a, nb, $sformatf("rw%0d", it));
            end else begin
                txn = int'($urandom_range(0, 7));
                len = int'($urandom_range(1, 6));
                do_read($urandom, txn, len, $sformatf("rr%0d", it));
            end
        end

        check("busy_low_at_pulses", 32'(n_busy_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
